// File: rtl/icon_channel_scheduler_pkg.sv
// rtl/icon_channel_scheduler_pkg.sv - shared types and defaults for the interconnect channel scheduler
package icon_channel_scheduler_pkg;

  // Default instruction queue depth is 2**ICON_IQUEUE_DEPTH_LOG2 entries
  localparam int ICON_IQUEUE_DEPTH_LOG2 = 2;

  typedef struct packed {
    logic [2:0] euidx;
    logic [1:0] uid;
    logic       spec;
  } type_exec_unit_addr;

  typedef logic [31:0] type_exec_unit_data;

  // Bits 0..3 are exec units eus[0..3], then the str buffer and the mx reg bank
  typedef logic [5:0] type_icon_receivers_list;
  localparam int RCV_STR   = 4;
  localparam int RCV_MXREG = 5;

  typedef struct packed {
    type_exec_unit_addr      src_addr;
    type_icon_receivers_list receiver_list;
  } type_icon_instr;

  typedef enum logic [1:0] {
    ICON_SCHED_IDLE,
    ICON_SCHED_REQ,
    ICON_SCHED_BCAST
  } enum_icon_sched_state;

  // Receivers still waiting after this cycle's accept strobes; strobes for
  // receivers that are not pending have no effect
  function automatic type_icon_receivers_list rcv_remaining(
    input type_icon_receivers_list pending,
    input type_icon_receivers_list success
  );
    return pending & ~success;
  endfunction

endpackage

// File: rtl/icon_instr_fifo.sv
// rtl/icon_instr_fifo.sv - circular instruction queue with occupancy count
module icon_instr_fifo #(
  parameter int WIDTH      = 12,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic [LOG2_DEPTH:0]   count
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FULL_COUNT = (LOG2_DEPTH + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Full refuses a push even when a pop frees a slot in the same cycle
  assign push_ready = (count != FULL_COUNT);
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop & (count != '0);
  assign head_data  = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define which entries are live
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/icon_channel_scheduler.sv
// rtl/icon_channel_scheduler.sv - fetch/broadcast sequencer for one interconnect channel
module icon_channel_scheduler
  import icon_channel_scheduler_pkg::*;
#(
  parameter int LOG2_ICON_IQUEUE_DEPTH = ICON_IQUEUE_DEPTH_LOG2
) (
  input  logic                              i_clk,
  input  logic                              reset,
  input  type_icon_instr                    i_instr,
  input  logic                              i_instr_valid,
  output logic                              o_instr_ready,
  output logic                              o_src_req_valid,
  output type_exec_unit_addr                o_src_addr,
  input  type_exec_unit_data                i_src_data,
  input  logic                              i_src_data_valid,
  output type_exec_unit_data                o_data,
  output logic                              o_data_valid,
  output type_icon_receivers_list           o_receiver_list,
  input  type_icon_receivers_list           i_success_list,
  output logic                              o_busy,
  output logic [LOG2_ICON_IQUEUE_DEPTH:0]   o_count
);

  enum_icon_sched_state    state;
  type_icon_receivers_list pending;
  type_icon_receivers_list remaining;
  type_icon_instr          head;
  logic                    bcast_done;
  logic                    load_now;

  icon_instr_fifo #(
    .WIDTH      ($bits(type_icon_instr)),
    .LOG2_DEPTH (LOG2_ICON_IQUEUE_DEPTH)
  ) u_fifo (
    .clk        (i_clk),
    .reset      (reset),
    .push_data  (i_instr),
    .push_valid (i_instr_valid),
    .push_ready (o_instr_ready),
    .pop        (load_now),
    .head_data  (head),
    .count      (o_count)
  );

  assign remaining  = rcv_remaining(pending, i_success_list);
  assign bcast_done = (state == ICON_SCHED_BCAST) && (remaining == '0);
  // A new instruction is taken from idle or straight off a completing broadcast
  assign load_now   = (o_count != '0) && ((state == ICON_SCHED_IDLE) || bcast_done);
  assign o_busy     = (state != ICON_SCHED_IDLE);

  // Sequencer: registered outputs are updated alongside the state they belong to
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state           <= ICON_SCHED_IDLE;
      pending         <= '0;
      o_src_addr      <= '0;
      o_data          <= '0;
      o_src_req_valid <= 1'b0;
      o_data_valid    <= 1'b0;
      o_receiver_list <= '0;
    end else begin
      case (state)
        ICON_SCHED_REQ: begin
          if (i_src_data_valid) begin
            o_data          <= i_src_data;
            o_src_req_valid <= 1'b0;
            o_data_valid    <= 1'b1;
            o_receiver_list <= pending;
            state           <= ICON_SCHED_BCAST;
          end
        end
        ICON_SCHED_BCAST: begin
          pending         <= remaining;
          o_receiver_list <= remaining;
          if (bcast_done) begin
            o_data_valid <= 1'b0;
            state        <= ICON_SCHED_IDLE;
          end
        end
        default: ;
      endcase
      // An empty receiver list is consumed without a fetch and retried next cycle
      if (load_now) begin
        o_src_addr <= head.src_addr;
        pending    <= head.receiver_list;
        if (head.receiver_list != '0) begin
          o_src_req_valid <= 1'b1;
          state           <= ICON_SCHED_REQ;
        end else begin
          state <= ICON_SCHED_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_icon_channel_scheduler.sv
// tb/tb_icon_channel_scheduler.sv - self-checking bench for icon_channel_scheduler
module tb_icon_channel_scheduler;
  import icon_channel_scheduler_pkg::*;

  localparam int LOG2D = 2;
  localparam int DEPTH = 1 << LOG2D;

  logic                    i_clk;
  logic                    reset;
  type_icon_instr          i_instr;
  logic                    i_instr_valid;
  logic                    o_instr_ready;
  logic                    o_src_req_valid;
  type_exec_unit_addr      o_src_addr;
  type_exec_unit_data      i_src_data;
  logic                    i_src_data_valid;
  type_exec_unit_data      o_data;
  logic                    o_data_valid;
  type_icon_receivers_list o_receiver_list;
  type_icon_receivers_list i_success_list;
  logic                    o_busy;
  logic [LOG2D:0]          o_count;

  icon_channel_scheduler #(.LOG2_ICON_IQUEUE_DEPTH(LOG2D)) dut (
    .i_clk            (i_clk),
    .reset            (reset),
    .i_instr          (i_instr),
    .i_instr_valid    (i_instr_valid),
    .o_instr_ready    (o_instr_ready),
    .o_src_req_valid  (o_src_req_valid),
    .o_src_addr       (o_src_addr),
    .i_src_data       (i_src_data),
    .i_src_data_valid (i_src_data_valid),
    .o_data           (o_data),
    .o_data_valid     (o_data_valid),
    .o_receiver_list  (o_receiver_list),
    .i_success_list   (i_success_list),
    .o_busy           (o_busy),
    .o_count          (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: instruction queue plus the phase of the current instruction
  type_icon_instr     mq[$];
  int                 m_phase;   // 0 idle, 1 fetching, 2 broadcasting
  type_exec_unit_addr m_addr;
  logic [31:0]        m_data;
  logic [5:0]         m_pend;

  typedef struct packed {
    logic               ready;
    logic               req;
    type_exec_unit_addr addr;
    logic [31:0]        data;
    logic               dvld;
    logic [5:0]         rcv;
    logic               busy;
    logic [2:0]         count;
  } obs_t;

  typedef struct {
    logic           v;
    type_icon_instr ins;
    logic           dv;
    logic [31:0]    d;
    logic [5:0]     s;
    logic           e_req;
    logic           e_dvld;
    logic [5:0]     e_rcv;
    logic           e_busy;
    logic [2:0]     e_count;
  } vec_t;

  function automatic type_icon_instr mk(input logic [2:0] eu, input logic [1:0] uid,
                                        input logic spec, input logic [5:0] rl);
    type_icon_instr r;
    r.src_addr.euidx = eu;
    r.src_addr.uid   = uid;
    r.src_addr.spec  = spec;
    r.receiver_list  = rl;
    return r;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_phase = 0;
    m_addr  = '0;
    m_data  = '0;
    m_pend  = '0;
  endfunction

  // One clock edge of the channel, computed from the inputs held across the edge
  function automatic void model_step();
    bit             can_push;
    bit             take;
    type_icon_instr h;
    can_push = i_instr_valid && (mq.size() < DEPTH);
    take = 0;
    if (m_phase == 0) begin
      take = (mq.size() > 0);
    end else if (m_phase == 1) begin
      if (i_src_data_valid) begin
        m_data  = i_src_data;
        m_phase = 2;
      end
    end else begin
      m_pend = m_pend & ~i_success_list;
      if (m_pend == 0) begin
        m_phase = 0;
        take = (mq.size() > 0);
      end
    end
    if (take) begin
      h       = mq.pop_front();
      m_addr  = h.src_addr;
      m_pend  = h.receiver_list;
      m_phase = (h.receiver_list != 0) ? 1 : 0;
    end
    if (can_push) mq.push_back(i_instr);
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.ready = (mq.size() < DEPTH);
    o.req   = (m_phase == 1);
    o.addr  = m_addr;
    o.data  = m_data;
    o.dvld  = (m_phase == 2);
    o.rcv   = (m_phase == 2) ? m_pend : 6'd0;
    o.busy  = (m_phase != 0);
    o.count = 3'(mq.size());
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.ready = o_instr_ready;
    o.req   = o_src_req_valid;
    o.addr  = o_src_addr;
    o.data  = o_data;
    o.dvld  = o_data_valid;
    o.rcv   = o_receiver_list;
    o.busy  = o_busy;
    o.count = o_count;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    obs_t a;
    obs_t e;
    a = dut_obs();
    e = model_obs();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, a, e);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ready"}, 32'(o_instr_ready), 32'd1);
    chk({tag, " req"},   32'(o_src_req_valid), 32'd0);
    chk({tag, " dvld"},  32'(o_data_valid), 32'd0);
    chk({tag, " busy"},  32'(o_busy), 32'd0);
    chk({tag, " addr"},  32'(o_src_addr), 32'd0);
    chk({tag, " data"},  o_data, 32'd0);
    chk({tag, " rcv"},   32'(o_receiver_list), 32'd0);
    chk({tag, " count"}, 32'(o_count), 32'd0);
  endtask

  // Drive inputs at the falling edge, clock once, check at the next falling edge
  task automatic cycle(input logic v, input type_icon_instr ins, input logic dv,
                       input logic [31:0] d, input logic [5:0] s);
    i_instr_valid    = v;
    i_instr          = ins;
    i_src_data_valid = dv;
    i_src_data       = d;
    i_success_list   = s;
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    chk_model("model");
  endtask

  task automatic idle_cycle();
    cycle(1'b0, '0, 1'b0, 32'd0, 6'd0);
  endtask

  vec_t           tbl[7];
  type_icon_instr ia;
  type_icon_instr fl[DEPTH+2];
  type_icon_instr b1, b2, ie, iv, isp;

  initial begin
    ia = mk(3'd1, 2'd2, 1'b0, 6'b001001);
    tbl[0] = '{1'b1, ia, 1'b0, 32'd0, 6'd0,    1'b0, 1'b0, 6'h00, 1'b0, 3'd1};
    tbl[1] = '{1'b0, '0, 1'b0, 32'd0, 6'd0,    1'b1, 1'b0, 6'h00, 1'b1, 3'd0};
    tbl[2] = '{1'b0, '0, 1'b0, 32'd0, 6'd0,    1'b1, 1'b0, 6'h00, 1'b1, 3'd0};
    tbl[3] = '{1'b0, '0, 1'b1, 32'hA5, 6'd0,   1'b0, 1'b1, 6'h09, 1'b1, 3'd0};
    tbl[4] = '{1'b0, '0, 1'b0, 32'd0, 6'h01,   1'b0, 1'b1, 6'h08, 1'b1, 3'd0};
    tbl[5] = '{1'b0, '0, 1'b0, 32'd0, 6'h08,   1'b0, 1'b0, 6'h00, 1'b0, 3'd0};
    tbl[6] = '{1'b0, '0, 1'b0, 32'd0, 6'd0,    1'b0, 1'b0, 6'h00, 1'b0, 3'd0};

    reset = 1'b1;
    i_instr = '0;
    i_instr_valid = 1'b0;
    i_src_data = '0;
    i_src_data_valid = 1'b0;
    i_success_list = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    reset = 1'b0;
    chk_reset_vals("reset");

    // Single instruction, table driven
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].v, tbl[i].ins, tbl[i].dv, tbl[i].d, tbl[i].s);
      chk($sformatf("tbl%0d req", i),   32'(o_src_req_valid), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d dvld", i),  32'(o_data_valid), 32'(tbl[i].e_dvld));
      chk($sformatf("tbl%0d rcv", i),   32'(o_receiver_list), 32'(tbl[i].e_rcv));
      chk($sformatf("tbl%0d busy", i),  32'(o_busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d count", i), 32'(o_count), 32'(tbl[i].e_count));
    end
    chk("single data", o_data, 32'hA5);
    chk("single addr", 32'(o_src_addr), 32'(ia.src_addr));

    // Fill to full while the first instruction waits for its operand
    for (int i = 0; i < DEPTH + 2; i++) begin
      fl[i] = mk(3'(i), 2'(i), 1'(i), 6'(i + 1));
      cycle(1'b1, fl[i], 1'b0, 32'd0, 6'd0);
    end
    chk("full count", 32'(o_count), 32'(DEPTH));
    chk("full ready", 32'(o_instr_ready), 32'd0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      chk($sformatf("fifo order %0d", i), 32'(o_src_addr), 32'(fl[i].src_addr));
      chk($sformatf("fifo req %0d", i), 32'(o_src_req_valid), 32'd1);
      cycle(1'b0, '0, 1'b1, 32'(100 + i), 6'd0);
      chk($sformatf("fifo data %0d", i), o_data, 32'(100 + i));
      cycle(1'b0, '0, 1'b0, 32'd0, 6'h3f);
    end
    chk("drained busy", 32'(o_busy), 32'd0);
    chk("drained count", 32'(o_count), 32'd0);

    // Back-to-back: completion of one broadcast loads the next with no idle gap
    b1 = mk(3'd2, 2'd1, 1'b1, 6'b110000);
    b2 = mk(3'd5, 2'd3, 1'b0, 6'b000110);
    cycle(1'b1, b1, 1'b0, 32'd0, 6'd0);
    cycle(1'b1, b2, 1'b0, 32'd0, 6'd0);
    cycle(1'b0, '0, 1'b1, 32'h11, 6'd0);
    chk("b2b bcast1", 32'(o_data_valid), 32'd1);
    cycle(1'b0, '0, 1'b0, 32'd0, 6'b110000);
    chk("b2b req2", 32'(o_src_req_valid), 32'd1);
    chk("b2b busy", 32'(o_busy), 32'd1);
    chk("b2b addr2", 32'(o_src_addr), 32'(b2.src_addr));
    cycle(1'b0, '0, 1'b1, 32'h22, 6'd0);
    cycle(1'b0, '0, 1'b0, 32'd0, 6'b000110);
    chk("b2b idle", 32'(o_busy), 32'd0);

    // Empty receiver list is skipped without a fetch
    ie = mk(3'd3, 2'd0, 1'b0, 6'd0);
    iv = mk(3'd4, 2'd1, 1'b1, 6'b100000);
    cycle(1'b1, ie, 1'b0, 32'd0, 6'd0);
    cycle(1'b1, iv, 1'b0, 32'd0, 6'd0);
    chk("empty noreq", 32'(o_src_req_valid), 32'd0);
    cycle(1'b0, '0, 1'b0, 32'd0, 6'd0);
    chk("empty next req", 32'(o_src_req_valid), 32'd1);
    chk("empty next addr", 32'(o_src_addr), 32'(iv.src_addr));
    cycle(1'b0, '0, 1'b1, 32'h33, 6'd0);
    chk("empty next bcast", 32'(o_receiver_list), 32'b100000);
    cycle(1'b0, '0, 1'b0, 32'd0, 6'b100000);

    // Success strobes for non-pending receivers are ignored
    isp = mk(3'd6, 2'd2, 1'b0, 6'b000100);
    cycle(1'b1, isp, 1'b0, 32'd0, 6'd0);
    idle_cycle();
    cycle(1'b0, '0, 1'b1, 32'h44, 6'd0);
    cycle(1'b0, '0, 1'b0, 32'd0, (6'd1 << RCV_STR) | (6'd1 << RCV_MXREG));
    chk("spurious dvld", 32'(o_data_valid), 32'd1);
    chk("spurious rcv", 32'(o_receiver_list), 32'b000100);
    cycle(1'b0, '0, 1'b0, 32'd0, 6'b000100);
    chk("spurious done", 32'(o_data_valid), 32'd0);

    // Reset in the middle of a broadcast with three instructions queued
    cycle(1'b1, mk(3'd1, 2'd1, 1'b0, 6'h01), 1'b0, 32'd0, 6'd0);
    cycle(1'b1, mk(3'd2, 2'd1, 1'b0, 6'h02), 1'b0, 32'd0, 6'd0);
    cycle(1'b1, mk(3'd3, 2'd1, 1'b0, 6'h04), 1'b1, 32'h55, 6'd0);
    cycle(1'b1, mk(3'd4, 2'd1, 1'b0, 6'h08), 1'b0, 32'd0, 6'd0);
    chk("pre-reset dvld", 32'(o_data_valid), 32'd1);
    chk("pre-reset count", 32'(o_count), 32'd3);
    i_instr_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_reset_vals("async reset");
    model_reset();
    @(posedge i_clk);
    @(negedge i_clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      chk("post-reset req", 32'(o_src_req_valid), 32'd0);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      type_icon_instr r;
      r.src_addr      = 6'($urandom);
      r.receiver_list = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom);
      cycle(1'($urandom_range(0, 1)), r, ($urandom_range(0, 2) == 0),
            $urandom, 6'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
